// File: rtl/cia_serial_peer_pkg.sv
// rtl/cia_serial_peer_pkg.sv - shared constants for the CIA serial peer
package cia_serial_pkg;

   localparam int BIT_CNT_W = 3;
   localparam logic LINE_IDLE = 1'b1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RX      = 3'd1;
   localparam logic [2:0] ST_TX_LOW  = 3'd2;
   localparam logic [2:0] ST_TX_HIGH = 3'd3;
   localparam logic [2:0] ST_TX_GAP  = 3'd4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cia_serial_peer_if.sv
// rtl/cia_serial_peer_if.sv - byte-side handshake bundle of the CIA serial peer
interface cia_serial_peer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_overrun;
   logic       rx_ack;

   modport master (
      output tx_data, tx_valid, rx_ack,
      input  tx_ready, tx_done, rx_data, rx_valid, rx_overrun
   );

   modport slave (
      input  tx_data, tx_valid, rx_ack,
      output tx_ready, tx_done, rx_data, rx_valid, rx_overrun
   );
endinterface

// File: rtl/cia_serial_peer_sync_edge.sv
// rtl/cia_serial_peer_sync_edge.sv - 2-FF synchroniser with rise/fall strobes
module cia_sync_edge #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic res_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic meta;
   logic q_d;

   // Resetting to the idle line level avoids a false edge after reset.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
         q_d  <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
         q_d  <= q;
      end
   end

   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/cia_serial_peer.sv
// rtl/cia_serial_peer.sv - drive-side partner for the CIA SP/CNT fast-serial link
module cia_serial_peer
   import cia_serial_pkg::*;
#(
   parameter int HALF_PERIOD = 4,
   parameter int TX_GAP      = 8,
   parameter int RX_TIMEOUT  = 1024
) (
   input  logic               clk,
   input  logic               res_n,
   input  logic               dir,
   cia_serial_peer_if.slave   bus,
   input  logic               cnt_in,
   input  logic               sp_in,
   output logic               cnt_out,
   output logic               sp_out,
   output logic               cnt_oe,
   output logic               sp_oe
);

   localparam int T_MAX = max3(HALF_PERIOD, TX_GAP, RX_TIMEOUT);
   localparam int TW    = $clog2(T_MAX) + 1;

   logic [2:0]           state;
   logic                 dir_q;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [7:0]           shreg;
   logic [TW-1:0]        timer;
   logic                 tx_done_q;
   logic [7:0]           rx_data_q;
   logic                 rx_valid_q;
   logic                 rx_overrun_q;
   logic                 pending;

   logic cnt_q, cnt_rise, cnt_fall;
   logic sp_s, sp_rise, sp_fall;
   logic unused_edges;
   logic [7:0] rx_byte;
   logic byte_done;

   cia_sync_edge #(.RESET_VAL(LINE_IDLE)) u_sync_cnt (
      .clk(clk), .res_n(res_n), .d(cnt_in), .q(cnt_q), .rise(cnt_rise), .fall(cnt_fall)
   );

   cia_sync_edge #(.RESET_VAL(LINE_IDLE)) u_sync_sp (
      .clk(clk), .res_n(res_n), .d(sp_in), .q(sp_s), .rise(sp_rise), .fall(sp_fall)
   );

   assign unused_edges = sp_rise | sp_fall | cnt_q;
   assign rx_byte      = {shreg[6:0], sp_s};
   assign byte_done    = (state == ST_RX) && cnt_fall && (bit_cnt == 3'd7);

   // dir_q only moves while idle, so it doubles as the output-enable.
   assign cnt_oe = dir_q;
   assign sp_oe  = dir_q;

   assign bus.tx_ready   = (state == ST_IDLE) && dir_q;
   assign bus.tx_done    = tx_done_q;
   assign bus.rx_data    = rx_data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.rx_overrun = rx_overrun_q;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state     <= ST_IDLE;
         dir_q     <= 1'b0;
         bit_cnt   <= '0;
         shreg     <= '0;
         timer     <= '0;
         cnt_out   <= LINE_IDLE;
         sp_out    <= LINE_IDLE;
         tx_done_q <= 1'b0;
      end else begin
         tx_done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               timer <= '0;
               if (dir_q && bus.tx_valid) begin
                  shreg   <= bus.tx_data;
                  sp_out  <= bus.tx_data[7];
                  cnt_out <= 1'b0;
                  bit_cnt <= '0;
                  state   <= ST_TX_LOW;
               end else if (!dir_q && cnt_fall) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 1'b1;
                  state   <= ST_RX;
               end else begin
                  dir_q <= dir;
               end
            end
            ST_RX: begin
               if (cnt_fall) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 1'b1;
                  timer   <= '0;
                  if (bit_cnt == 3'd7)
                     state <= ST_IDLE;
               end else if (cnt_rise) begin
                  timer <= '0;
               end else if (timer == TW'(RX_TIMEOUT - 1)) begin
                  bit_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_TX_LOW: begin
               if (timer == TW'(HALF_PERIOD - 1)) begin
                  timer   <= '0;
                  cnt_out <= 1'b1;
                  state   <= ST_TX_HIGH;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_TX_HIGH: begin
               if (timer == TW'(HALF_PERIOD - 1)) begin
                  timer <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx_done_q <= 1'b1;
                     sp_out    <= LINE_IDLE;
                     bit_cnt   <= '0;
                     state     <= ST_TX_GAP;
                  end else begin
                     // SP moves together with the CNT falling edge only.
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= {shreg[6:0], 1'b0};
                     sp_out  <= shreg[6];
                     cnt_out <= 1'b0;
                     state   <= ST_TX_LOW;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_TX_GAP: begin
               if (timer == TW'(TX_GAP - 1)) begin
                  timer <= '0;
                  state <= ST_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A new byte beats a same-cycle ack, so the pending flag survives it.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
         pending      <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (byte_done) begin
            rx_data_q  <= rx_byte;
            rx_valid_q <= 1'b1;
            if (pending)
               rx_overrun_q <= 1'b1;
            pending <= 1'b1;
         end else if (bus.rx_ack) begin
            pending      <= 1'b0;
            rx_overrun_q <= 1'b0;
         end
      end
   end

endmodule
